// File: rtl/ace_pkg.sv
// rtl/ace_pkg.sv - shared constants and slot-owner encoding for the video RAM arbiter
package ace_pkg;

  localparam int ACE_AW     = 10;
  localparam int ACE_DW     = 8;
  localparam int ACE_STARVE = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VID   = 2'd1,
    S_CPURD = 2'd2
  } owner_t;

endpackage

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video/char RAM arbiter, video priority with CPU starvation guard
module vram_arbiter
  import ace_pkg::*;
#(
  parameter int AW     = ACE_AW,
  parameter int DW     = ACE_DW,
  parameter int STARVE = ACE_STARVE
) (
  input  logic          clkram,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_rvalid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  // Saturation point of the starvation counter; the counter is 4 bits wide.
  localparam logic [3:0] STARVE_LIM = 4'(STARVE);

  owner_t     owner;
  owner_t     owner_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       cpu_forced;

  // Grant decision and RAM port steering; everything is held idle while reset is high.
  always_comb begin
    cpu_forced = 1'b0;
    vid_ack    = 1'b0;
    cpu_ack    = 1'b0;
    cpu_wait   = 1'b0;
    ram_addr   = vid_addr;
    ram_we     = 1'b0;
    ram_wdata  = cpu_wdata;
    if (!reset) begin
      // CPU overrides video once it has been held off for STARVE cycles in a row.
      cpu_forced = cpu_req && (starve_cnt == STARVE_LIM);
      vid_ack    = vid_req && !cpu_forced;
      cpu_ack    = cpu_req && !vid_ack;
      cpu_wait   = cpu_req && !cpu_ack;
      ram_we     = cpu_ack && cpu_we;
      if (cpu_ack) begin
        ram_addr = cpu_addr;
      end
    end
  end

  // Next slot owner (who collects read data next cycle) and next starvation count.
  always_comb begin
    owner_nxt  = S_IDLE;
    starve_nxt = starve_cnt;
    if (vid_ack) begin
      owner_nxt = S_VID;
    end else if (cpu_ack && !cpu_we) begin
      owner_nxt = S_CPURD;
    end
    if (cpu_ack || !cpu_req) begin
      starve_nxt = 4'd0;
    end else if (starve_cnt < STARVE_LIM) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  // State registers; reset discards any read still in flight.
  always_ff @(posedge clkram) begin
    if (reset) begin
      owner      <= S_IDLE;
      starve_cnt <= 4'd0;
    end else begin
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Read data is shared; the valid strobe tells which requester owns it.
  assign vid_rvalid = !reset && (owner == S_VID);
  assign cpu_rvalid = !reset && (owner == S_CPURD);
  assign vid_rdata  = ram_rdata;
  assign cpu_rdata  = ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with behavioural arbitration model
module tb_vram_arbiter;

  localparam int AW     = 10;
  localparam int DW     = 8;
  localparam int STARVE = 4;

  logic          clkram = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;
  logic          vid_rvalid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          cpu_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: consecutive CPU denials and the read expected next cycle.
  int            deny_cnt = 0;
  bit            pend_v   = 0;
  bit            pend_c   = 0;
  logic [DW-1:0] pend_data;
  bit            g_ev, g_ec;
  logic          obs_cack, obs_wait, obs_we;

  always #5 clkram = ~clkram;

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .clkram(clkram), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_wait(cpu_wait),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM with a backdoor preload port.
  always @(posedge clkram) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock of stimulus: check mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit cpu_turn, ev, ec, exp_wait, exp_vv, exp_cv;
    #3;
    ev = 0;
    ec = 0;
    if (!reset) begin
      cpu_turn = cpu_req && (deny_cnt >= STARVE);
      ev = vid_req && !cpu_turn;
      ec = cpu_req && !ev;
    end
    exp_wait = !reset && cpu_req && !ec;
    exp_vv   = !reset && pend_v;
    exp_cv   = !reset && pend_c;
    chk("vid_ack", 32'(vid_ack), 32'(ev));
    chk("cpu_ack", 32'(cpu_ack), 32'(ec));
    chk("cpu_wait", 32'(cpu_wait), 32'(exp_wait));
    chk("ram_we", 32'(ram_we), 32'(ec && cpu_we));
    chk("ram_addr", 32'(ram_addr), 32'(ec ? cpu_addr : vid_addr));
    if (ec && cpu_we) chk("ram_wdata", 32'(ram_wdata), 32'(cpu_wdata));
    chk("vid_rvalid", 32'(vid_rvalid), 32'(exp_vv));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cv));
    if (exp_vv) chk("vid_rdata", 32'(vid_rdata), 32'(pend_data));
    if (exp_cv) chk("cpu_rdata", 32'(cpu_rdata), 32'(pend_data));
    g_ev = ev;
    g_ec = ec;
    obs_cack = cpu_ack;
    obs_wait = cpu_wait;
    obs_we   = ram_we;
    @(posedge clkram);
    #1;
    if (reset) begin
      deny_cnt = 0;
      pend_v   = 0;
      pend_c   = 0;
    end else begin
      pend_v = ev;
      pend_c = ec && !cpu_we;
      pend_data = ev ? shadow[vid_addr] : shadow[cpu_addr];
      if (ec && cpu_we) shadow[cpu_addr] = cpu_wdata;
      if (!cpu_req || ec) deny_cnt = 0;
      else if (deny_cnt < STARVE) deny_cnt++;
    end
  endtask

  initial begin : main
    logic [DW-1:0] d;
    logic [9:0]    pattern;
    int            waits, wes;

    reset = 1; vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0;
    cpu_addr = '0; cpu_wdata = '0; bd_we = 0; bd_addr = '0; bd_data = '0;

    // Preload RAM and shadow while reset is held.
    for (int i = 0; i < (1 << AW); i++) begin
      d = (i == 'h123) ? 8'h5A : 8'($urandom);
      bd_addr = AW'(i); bd_data = d; bd_we = 1;
      shadow[i] = d;
      @(posedge clkram); #1;
    end
    bd_we = 0;

    // Reset state with both requests raised: everything must stay quiet.
    vid_req = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 10'h055;
    cycle();
    cycle();

    // First cycle after reset: a lone CPU read of 0x123 is served at once.
    reset = 0; vid_req = 0; cpu_we = 0; cpu_addr = 10'h123;
    cycle();
    chk("rd123_wait", 32'(obs_wait), 32'd0);
    cpu_req = 0;
    chk("rd123_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd123_data", 32'(cpu_rdata), 32'h5A);
    cycle();

    // Both requesters held: V,V,V,V,C repeating.
    vid_req = 1; cpu_req = 1; cpu_we = 0;
    waits = 0;
    for (int i = 0; i < 10; i++) begin
      vid_addr = AW'($urandom); cpu_addr = AW'($urandom);
      cycle();
      pattern[i] = obs_cack;
      waits += int'(obs_wait);
    end
    chk("starve_pattern", 32'(pattern), 32'b1000010000);
    chk("starve_waits", 32'(waits), 32'd8);
    vid_req = 0; cpu_req = 0;
    cycle();

    // CPU write 0xA7 to 0x3FF, then video reads it back.
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h3FF; cpu_wdata = 8'hA7;
    wes = 0;
    cycle();
    wes += int'(obs_we);
    cpu_req = 0; cpu_we = 0; vid_req = 1; vid_addr = 10'h3FF;
    cycle();
    wes += int'(obs_we);
    vid_req = 0;
    chk("wr_vid_rdata", 32'(vid_rdata), 32'hA7);
    cycle();
    wes += int'(obs_we);
    chk("wr_we_count", 32'(wes), 32'd1);

    // Reset asserted right after a video grant drops the pending read.
    vid_req = 1; vid_addr = 10'h010;
    cycle();
    vid_req = 0; reset = 1;
    cycle();
    reset = 0;
    cycle();

    // Alternating single reads every cycle.
    for (int i = 0; i < 12; i++) begin
      vid_req = (i % 2 == 0); cpu_req = (i % 2 == 1); cpu_we = 0;
      vid_addr = AW'($urandom); cpu_addr = AW'($urandom);
      cycle();
    end
    vid_req = 0; cpu_req = 0;
    cycle();

    // Random traffic; requests hold until acknowledged, occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (!(vid_req && !g_ev)) begin
        vid_req = 1'($urandom_range(0, 1));
        vid_addr = AW'($urandom);
      end
      if (!(cpu_req && !g_ec)) begin
        cpu_req = 1'($urandom_range(0, 1));
        cpu_we = ($urandom_range(0, 3) == 0);
        cpu_addr = AW'($urandom);
        cpu_wdata = DW'($urandom);
      end
      reset = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset = 0; vid_req = 0; cpu_req = 0;
    cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, RAM address width (1 KB video/char RAM).
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter STARVE, default 4, max consecutive cycles CPU may be denied while requesting (range 1..15).
REQ-004 SHALL have port clkram  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port vid_req  input  1  video fetch request, held until vid_ack.
REQ-007 SHALL have port vid_addr  input  AW  video read address.
REQ-008 SHALL have port vid_ack  output  1  video granted this cycle.
REQ-009 SHALL have port vid_rdata  output  DW  video read data.
REQ-010 SHALL have port vid_rvalid  output  1  vid_rdata valid, one-cycle pulse.
REQ-011 SHALL have port cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-012 SHALL have port cpu_we  input  1  1 = write, 0 = read.
REQ-013 SHALL have port cpu_addr  input  AW  CPU address.
REQ-014 SHALL have port cpu_wdata  input  DW  CPU write data.
REQ-015 SHALL have port cpu_ack  output  1  CPU granted this cycle.
REQ-016 SHALL have port cpu_rdata  output  DW  CPU read data.
REQ-017 SHALL have port cpu_rvalid  output  1  cpu_rdata valid, one-cycle pulse (reads only).
REQ-018 SHALL have port cpu_wait  output  1  cpu_req high and not granted this cycle (drives Z80 WAIT).
REQ-019 SHALL have ports ram_addr output AW, ram_we output 1, ram_wdata output DW, ram_rdata input DW: single-port synchronous RAM, read data one cycle after address.

Function
REQ-020 SHALL grant at most one requester per cycle; grant, ack, ram_addr, ram_we, ram_wdata combinational from current inputs and registered state.
REQ-021 SHALL grant video when vid_req high, except when starve_cnt equals STARVE and cpu_req high, in which case CPU is granted.
REQ-022 SHALL grant CPU when cpu_req high and video not granted.
REQ-023 SHALL drive ram_addr = granted requester's address; ram_we = cpu_ack & cpu_we; ram_wdata = cpu_wdata; with no grant ram_addr holds vid_addr and ram_we = 0.
REQ-024 SHALL keep starve_cnt (4-bit): reset to 0 on cpu_ack or when cpu_req low; increment, saturating at STARVE, when cpu_req high and not granted.
REQ-025 SHALL keep slot-owner FSM, states S_IDLE, S_VID, S_CPURD; next state S_VID on vid_ack, S_CPURD on cpu_ack with cpu_we=0, else S_IDLE (CPU write -> S_IDLE).
REQ-026 SHALL assert vid_rvalid in the cycle where owner = S_VID, cpu_rvalid where owner = S_CPURD; vid_rdata and cpu_rdata both wired to ram_rdata.
REQ-027 SHALL give read latency exactly 1 cycle from ack to rvalid; back-to-back grants sustain one access per cycle.
REQ-028 SHALL assert cpu_wait = cpu_req & ~cpu_ack combinationally; cpu_wait low when cpu_req low.
REQ-029 SHALL treat simultaneous vid_req and cpu_req with starve_cnt < STARVE as video win; CPU win at STARVE leaves vid_req pending, served next cycle.
REQ-030 SHALL never assert both acks, nor both rvalids, in one cycle.

Reset
REQ-031 SHALL, while reset high, force owner = S_IDLE, starve_cnt = 0, vid_ack = cpu_ack = 0, ram_we = 0, vid_rvalid = cpu_rvalid = 0, cpu_wait = 0.
REQ-032 SHALL discard an in-flight read when reset asserts mid-access: no rvalid in the cycle after reset.
REQ-033 SHALL accept requests in the first cycle after reset deasserts.

Structure
REQ-034 SHALL place owner-state encoding (2-bit) and default AW/DW/STARVE constants in shared package ace_pkg.
REQ-035 SHALL be implemented as one flat module; no sub-module.

Verification
REQ-036 SHALL verify: cpu_req read addr 0x123 alone (RAM[0x123]=0x5A) -> cpu_ack same cycle, cpu_rvalid next cycle, cpu_rdata=0x5A, cpu_wait never high.
REQ-037 SHALL verify: vid_req and cpu_req held continuously, STARVE=4 -> pattern V,V,V,V,C repeating; cpu_wait high 4 cycles, low on ack cycle.
REQ-038 SHALL verify: cpu write 0xA7 to 0x3FF then video read 0x3FF -> ram_we one cycle only, vid_rdata=0xA7, no cpu_rvalid.
REQ-039 SHALL verify: reset asserted cycle after vid_ack -> vid_rvalid stays 0, all outputs at REQ-031 values.
REQ-040 SHALL verify: alternating single vid/cpu reads every cycle -> one ack per cycle, rvalid routed to correct requester, no both-ack cycle.
